// File: rtl/n_shift_pkg.sv
// Shared opcodes and helpers for the universal shift register family.
package n_shift_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'b000;
  localparam op_t OP_SHL  = 3'b001;
  localparam op_t OP_SHR  = 3'b010;
  localparam op_t OP_ROL  = 3'b011;
  localparam op_t OP_ROR  = 3'b100;
  localparam op_t OP_LOAD = 3'b101;
  localparam op_t OP_ASR  = 3'b110;
  localparam op_t OP_CLR  = 3'b111;

  // Ops that move a lane and therefore advance the frame counter.
  function automatic logic is_step_op(input op_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Step counter that wraps after STEPS steps and emits a one-cycle done pulse on the wrap.
module shift_frame_cnt #(
  parameter int STEPS = 8,
  parameter int CW    = $clog2(STEPS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          step,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (clr) begin
          cnt <= '0;
        end else if (step) begin
          if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/n_univ_shift_reg.sv
// N-bit universal shift register moving W bits per step, with registered serial-out and frame counter.
// Optional registered parity output enabled by defining N_UNIV_SHIFT_REG_PARITY_EN.
module n_univ_shift_reg
  import n_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [2:0]                op,
  input  logic [W-1:0]              sin,
  input  logic [N-1:0]              pin,
  output logic [N-1:0]              pout,
  output logic [W-1:0]              sout,
  output logic [$clog2(N/W):0]      shift_cnt,
  output logic                      frame_done
`ifdef N_UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic                      parity
`endif
);

  if (N < 2 || W < 1 || W >= N || (N % W) != 0) begin : g_bad_params
    $fatal(1, "n_univ_shift_reg: need N >= 2, 1 <= W < N and N %% W == 0");
  end

  localparam int STEPS = N / W;

  logic [N-1:0] q, q_nxt;
  logic [W-1:0] sout_nxt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    unique case (op)
      OP_SHL: begin
        q_nxt    = {q[N-W-1:0], sin};
        sout_nxt = q[N-1:N-W];
      end
      OP_SHR: begin
        q_nxt    = {sin, q[N-1:W]};
        sout_nxt = q[W-1:0];
      end
      OP_ROL: begin
        q_nxt    = {q[N-W-1:0], q[N-1:N-W]};
        sout_nxt = q[N-1:N-W];
      end
      OP_ROR: begin
        q_nxt    = {q[W-1:0], q[N-1:W]};
        sout_nxt = q[W-1:0];
      end
      OP_LOAD: begin
        q_nxt    = pin;
        sout_nxt = '0;
      end
      OP_ASR: begin
        q_nxt    = {{W{q[N-1]}}, q[N-1:W]};
        sout_nxt = q[W-1:0];
      end
      OP_CLR: begin
        q_nxt    = '0;
        sout_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      sout <= '0;
    end else if (en) begin
      q    <= q_nxt;
      sout <= sout_nxt;
    end
  end

`ifdef N_UNIV_SHIFT_REG_PARITY_EN
  // Parity tracks the value q takes on this edge, so it never lags pout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     parity <= 1'b0;
    else if (en) parity <= ^q_nxt;
  end
`endif

  shift_frame_cnt #(
    .STEPS (STEPS),
    .CW    ($clog2(STEPS) + 1)
  ) u_frame_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .step (is_step_op(op)),
    .clr  ((op == OP_LOAD) || (op == OP_CLR)),
    .cnt  (shift_cnt),
    .done (frame_done)
  );

  assign pout = q;

endmodule

// File: tb/tb_n_univ_shift_reg.sv
// Directed bench for n_univ_shift_reg: one instance with W=1 and one with W=2, both N=8.
module tb_n_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'b000, SHL = 3'b001, SHR = 3'b010, ROL = 3'b011;
  localparam logic [2:0] ROR  = 3'b100, LOAD = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: N=8, W=1
  logic       a_en = 1'b0;
  logic [2:0] a_op = HOLD;
  logic [0:0] a_sin = '0;
  logic [7:0] a_pin = '0;
  logic [7:0] a_pout;
  logic [0:0] a_sout;
  logic [3:0] a_cnt;
  logic       a_done;
`ifdef N_UNIV_SHIFT_REG_PARITY_EN
  logic       a_par;
  logic       b_par;
`endif

  // Instance B: N=8, W=2
  logic       b_en = 1'b0;
  logic [2:0] b_op = HOLD;
  logic [1:0] b_sin = '0;
  logic [7:0] b_pin = '0;
  logic [7:0] b_pout;
  logic [1:0] b_sout;
  logic [2:0] b_cnt;
  logic       b_done;

  n_univ_shift_reg #(.N(8), .W(1)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .op(a_op), .sin(a_sin), .pin(a_pin),
    .pout(a_pout), .sout(a_sout), .shift_cnt(a_cnt), .frame_done(a_done)
`ifdef N_UNIV_SHIFT_REG_PARITY_EN
    , .parity(a_par)
`endif
  );

  n_univ_shift_reg #(.N(8), .W(2)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .op(b_op), .sin(b_sin), .pin(b_pin),
    .pout(b_pout), .sout(b_sout), .shift_cnt(b_cnt), .frame_done(b_done)
`ifdef N_UNIV_SHIFT_REG_PARITY_EN
    , .parity(b_par)
`endif
  );

  // Apply one op to A across a rising edge; outputs settle 1 time unit later.
  task automatic step_a(input logic en, input logic [2:0] op, input logic sin, input logic [7:0] pin);
    a_en = en; a_op = op; a_sin = sin; a_pin = pin;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic en, input logic [2:0] op, input logic [1:0] sin, input logic [7:0] pin);
    b_en = en; b_op = op; b_sin = sin; b_pin = pin;
    @(posedge clk); #1;
  endtask

  task automatic exp_a(input string name, input logic [7:0] p, input logic s, input logic [3:0] c, input logic d);
    checks++;
    if (a_pout !== p || a_sout !== s || a_cnt !== c || a_done !== d) begin
      failures++;
      $display("FAIL %s: got pout=%h sout=%b cnt=%0d done=%b, want pout=%h sout=%b cnt=%0d done=%b",
               name, a_pout, a_sout, a_cnt, a_done, p, s, c, d);
    end
  endtask

  task automatic exp_b(input string name, input logic [7:0] p, input logic [1:0] s, input logic [2:0] c, input logic d);
    checks++;
    if (b_pout !== p || b_sout !== s || b_cnt !== c || b_done !== d) begin
      failures++;
      $display("FAIL %s: got pout=%h sout=%b cnt=%0d done=%b, want pout=%h sout=%b cnt=%0d done=%b",
               name, b_pout, b_sout, b_cnt, b_done, p, s, c, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_a("reset_a", 8'h00, 1'b0, 4'd0, 1'b0);
    exp_b("reset_b", 8'h00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_hold();
    step_a(1'b1, LOAD, 1'b0, 8'hA5);
    exp_a("load", 8'hA5, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, SHL, 1'b1, 8'h00);
      exp_a($sformatf("en_low_%0d", i), 8'hA5, 1'b0, 4'd0, 1'b0);
    end
    step_a(1'b1, HOLD, 1'b1, 8'h00);
    exp_a("op_hold", 8'hA5, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_shl_frame();
    logic [3:0] bits;
    logic [7:0] exp_q;
    bits  = 4'b1011;
    exp_q = 8'h00;
    step_a(1'b1, CLR, 1'b0, 8'h00);
    exp_a("clear", 8'h00, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, SHL, bits[3-i], 8'h00);
      exp_q = {exp_q[6:0], bits[3-i]};
    end
    exp_a("shl_4", 8'h0B, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) step_a(1'b1, SHL, 1'b0, 8'h00);
    exp_a("shl_7", 8'h58, 1'b0, 4'd7, 1'b0);
    step_a(1'b1, SHL, 1'b0, 8'h00);
    exp_a("shl_8_wrap", 8'hB0, 1'b0, 4'd0, 1'b1);
    // Back-to-back step after wrap: no bubble, pulse drops
    step_a(1'b1, ROL, 1'b0, 8'h00);
    exp_a("rol_after_wrap", 8'h61, 1'b1, 4'd1, 1'b0);
    step_a(1'b1, SHR, 1'b1, 8'h00);
    exp_a("shr_dir_change", 8'hB0, 1'b1, 4'd2, 1'b0);
    step_a(1'b0, HOLD, 1'b0, 8'h00);
  endtask

  task automatic test_rotate_w2();
    step_b(1'b1, LOAD, 2'b11, 8'h81);
    exp_b("w2_load", 8'h81, 2'b00, 3'd0, 1'b0);
    step_b(1'b1, ROL, 2'b11, 8'h00);
    exp_b("w2_rol", 8'h06, 2'b10, 3'd1, 1'b0);
    step_b(1'b1, ROR, 2'b11, 8'h00);
    exp_b("w2_ror", 8'h81, 2'b10, 3'd2, 1'b0);
  endtask

  task automatic test_asr_w2();
    step_b(1'b1, LOAD, 2'b00, 8'h90);
    exp_b("asr_load", 8'h90, 2'b00, 3'd0, 1'b0);
    step_b(1'b1, ASR, 2'b00, 8'h00);
    exp_b("asr_1", 8'hE4, 2'b00, 3'd1, 1'b0);
    step_b(1'b1, ASR, 2'b00, 8'h00);
    exp_b("asr_2", 8'hF9, 2'b00, 3'd2, 1'b0);
    step_b(1'b1, ASR, 2'b00, 8'h00);
    exp_b("asr_3", 8'hFE, 2'b01, 3'd3, 1'b0);
    step_b(1'b1, ASR, 2'b00, 8'h00);
    exp_b("asr_4_wrap", 8'hFF, 2'b10, 3'd0, 1'b1);
    step_b(1'b0, ASR, 2'b00, 8'h00);
    exp_b("asr_en_low", 8'hFF, 2'b10, 3'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    step_a(1'b1, LOAD, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) step_a(1'b1, SHL, 1'b0, 8'h00);
    exp_a("pre_reset", 8'hF8, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_a("async_reset", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_a(1'b1, SHL, 1'b1, 8'h00);
    exp_a("after_release", 8'h01, 1'b0, 4'd1, 1'b0);
  endtask

`ifdef N_UNIV_SHIFT_REG_PARITY_EN
  task automatic test_parity();
    step_a(1'b1, LOAD, 1'b0, 8'h07);
    checks++;
    if (a_par !== 1'b1) begin
      failures++;
      $display("FAIL parity_load: got %b want 1", a_par);
    end
    step_a(1'b1, SHL, 1'b1, 8'h00);
    checks++;
    if (a_pout !== 8'h0F || a_par !== 1'b0) begin
      failures++;
      $display("FAIL parity_shl: got pout=%h parity=%b want pout=0f parity=0", a_pout, a_par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_hold();
    test_shl_frame();
    test_rotate_w2();
    test_asr_w2();
    test_async_reset();
`ifdef N_UNIV_SHIFT_REG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n_univ_shift_reg.md
Name: n_univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the single-bit left/right shift register.
- Shifts W bits per step and adds rotate, arithmetic shift, parallel load, clear and hold.
- Provides a registered serial-out lane and a frame counter that pulses after N/W shift steps.
- Serves as the building block for serialiser/deserialiser and bit-manipulation datapaths in the sequential library.

Parameters:
N  8  register width in bits; N >= 2
W  1  lane width (bits moved per shift step); 1 <= W < N and N % W == 0, checked at elaboration (fatal on violation)

Ports:
clk         input   1             clock, rising edge
rst         input   1             asynchronous, active-high reset
en          input   1             step enable; 0 = hold everything
op          input   3             operation select (encodings below)
sin         input   W             serial-in lane
pin         input   N             parallel load data
pout        output  N             register contents q
sout        output  W             lane shifted/rotated out on the last step (registered)
shift_cnt   output  $clog2(N/W)+1 shift/rotate steps since last LOAD/CLEAR/wrap
frame_done  output  1             one-cycle pulse when the N/W-th step completes

Behaviour:
- Reset (async, rst=1): q=0, sout=0, shift_cnt=0, frame_done=0; held while rst is high. Mid-operation reset discards everything; the first edge after release acts on the op present then.
- All updates on the rising clk edge when en=1; en=0 holds q, sout and shift_cnt, and forces frame_done=0.
- op encodings:
  - 000 HOLD: q, sout and shift_cnt unchanged.
  - 001 SHL: q <= {q[N-W-1:0], sin}; sout <= q[N-1:N-W].
  - 010 SHR: q <= {sin, q[N-1:W]}; sout <= q[W-1:0].
  - 011 ROL: q <= {q[N-W-1:0], q[N-1:N-W]}; sout <= q[N-1:N-W].
  - 100 ROR: q <= {q[W-1:0], q[N-1:W]}; sout <= q[W-1:0].
  - 101 LOAD: q <= pin; sout <= 0; shift_cnt <= 0.
  - 110 ASR: q <= {W copies of q[N-1], q[N-1:W]}; sout <= q[W-1:0]; sin ignored.
  - 111 CLEAR: q <= 0; sout <= 0; shift_cnt <= 0.
- Step ops: SHL, SHR, ROL, ROR, ASR.
  - On a step with shift_cnt == N/W-1: shift_cnt <= 0 and frame_done <= 1 for exactly one cycle.
  - Otherwise shift_cnt increments and frame_done <= 0.
- HOLD, LOAD and CLEAR drive frame_done <= 0.
- Latency: all outputs are registers and reflect the op one cycle after the sampling edge. No combinational path from inputs to outputs.
- N/W == 1 is not reachable, because W < N is required. N/W == 2 gives a frame_done pulse every second step.
- Back-to-back steps with wrap: the counter continues 0,1,... with no bubble cycle.
- Direction may change every cycle; shift_cnt counts steps regardless of direction.

Optional Feature:
- Macro: N_UNIV_SHIFT_REG_PARITY_EN.
- Defined: adds output port parity (1 bit, registered) = XOR-reduction of the next q value, updated on the same edge as q. Reset value 0; holds when en=0.
- Undefined: no parity port and no parity logic.

Decomposition:
- Package n_shift_pkg:
  - localparams OP_HOLD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_LOAD, OP_ASR, OP_CLR (3-bit).
  - Function is_step_op(op).
- Sub-module shift_frame_cnt (params STEPS=N/W):
  - Ports: clk, rst, en, step, clr → cnt, done.
  - Implements the wrap counter and the done pulse.
- The top level holds the datapath mux and the q/sout registers.

Test Plan:
- N=8, W=1: reset, LOAD pin=8'hA5, then hold en=0 for 3 cycles → pout=8'hA5, shift_cnt=0, frame_done=0 throughout.
- N=8, W=1: CLEAR, SHL with sin=1,0,1,1 → pout=8'h0B, shift_cnt=4. Then 4 more SHL with sin=0 → pout=8'hB0, frame_done high exactly on the cycle after the 8th step, shift_cnt=0.
- N=8, W=2: LOAD 8'h81, ROL ×1 → pout=8'h06, sout=2'b10. Then ROR ×1 → pout=8'h81, sout=2'b10.
- N=8, W=2: LOAD 8'h90, ASR ×2 → pout=8'hF9 then 8'hFE. sout=2'b00 then 2'b01.
- Assert rst asynchronously mid-frame (shift_cnt=3, between edges) → pout, sout and shift_cnt read 0 immediately, before the next edge. First SHL after release gives shift_cnt=1.
- With N_UNIV_SHIFT_REG_PARITY_EN, N=8: LOAD 8'h07 → parity=1. SHL sin=1 → pout=8'h0F, parity=0.
